// File: rtl/matrix_mult_mxn_pkg.sv
// Shared types and helpers for the rectangular fixed-point matrix multiplier.
//   state_e    : controller states (IDLE, RUN, DONE)
//   acc_width  : accumulator width that cannot overflow over K signed products
//   sat_shift  : floor-shift an accumulator by FRAC and clamp to WIDTH bits,
//                returning {flag, value}. Supports ACCW <= 128 and WIDTH <= 64.
package mat_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned acc_width(input int unsigned width, input int unsigned k);
        return 2 * width + $clog2(k + 1) + 1;
    endfunction

    function automatic logic [64:0] sat_shift(input logic signed [127:0] acc,
                                              input int unsigned        frac,
                                              input int unsigned        width);
        logic signed [127:0] shifted;
        logic signed [127:0] max_v;
        logic signed [127:0] min_v;
        shifted = acc >>> frac;
        max_v   = (128'sd1 <<< (width - 1)) - 128'sd1;
        min_v   = -(128'sd1 <<< (width - 1));
        if (shifted > max_v) begin
            return {1'b1, max_v[63:0]};
        end else if (shifted < min_v) begin
            return {1'b1, min_v[63:0]};
        end
        return {1'b0, shifted[63:0]};
    endfunction

endpackage

// File: rtl/matrix_mult_mxn_if.sv
// Operand/result bundle for matrix_mult_mxn.
//   start, acc_mode, trans_b : command (master -> slave)
//   A [M][K], B [K][N], C_in [M][N] : operands, WIDTH-bit two's complement
//   Res [M][N], busy, done, sat : registered results and status (slave -> master)
interface matrix_mult_mxn_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned M     = 4,
    parameter int unsigned K     = 4,
    parameter int unsigned N     = 4
);
    logic                              start;
    logic                              acc_mode;
    logic                              trans_b;
    logic [M-1:0][K-1:0][WIDTH-1:0]    A;
    logic [K-1:0][N-1:0][WIDTH-1:0]    B;
    logic [M-1:0][N-1:0][WIDTH-1:0]    C_in;
    logic [M-1:0][N-1:0][WIDTH-1:0]    Res;
    logic                              busy;
    logic                              done;
    logic                              sat;

    modport master (
        output start, acc_mode, trans_b, A, B, C_in,
        input  Res, busy, done, sat
    );

    modport slave (
        input  start, acc_mode, trans_b, A, B, C_in,
        output Res, busy, done, sat
    );
endinterface

// File: rtl/matrix_mult_mxn_mac_cell.sv
// One multiply-accumulate element of the result matrix.
//   load_i : initialise the accumulator with init_i
//   en_i   : add a_i*b_i (full-precision product) to the accumulator
//   last_i : with en_i, also register the floor-shifted, saturated result
//   res_o / sat_o : registered element and its saturation flag
module mac_cell
    import mat_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned ACCW  = 37
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_i,
    input  logic                    en_i,
    input  logic                    last_i,
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_i,
    input  logic signed [ACCW-1:0]  init_i,
    output logic signed [WIDTH-1:0] res_o,
    output logic                    sat_o
);
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACCW-1:0]    sum;
    logic signed [ACCW-1:0]    acc_q, acc_d;
    logic signed [WIDTH-1:0]   res_q, res_d;
    logic                      sat_q, sat_d;
    logic [64:0]               shifted;

    always_comb begin
        acc_d   = acc_q;
        res_d   = res_q;
        sat_d   = sat_q;
        prod    = a_i * b_i;
        sum     = acc_q + ACCW'(prod);
        // Result is taken from the final sum, so it is ready on the last RUN edge.
        shifted = sat_shift(128'(sum), FRAC, WIDTH);
        if (load_i) begin
            acc_d = init_i;
        end else if (en_i) begin
            acc_d = sum;
            if (last_i) begin
                res_d = WIDTH'(shifted[63:0]);
                sat_d = shifted[64];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            res_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            res_q <= res_d;
            sat_q <= sat_d;
        end
    end

    assign res_o = res_q;
    assign sat_o = sat_q;
endmodule

// File: rtl/matrix_mult_mxn.sv
// Rectangular fixed-point matrix multiplier: Res = A*B or C_in + A*B, optional B
// transpose (square B only). One inner-product index per enabled cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   clk_en     : global enable; all state holds when low
//   bus        : command, operands, registered results and status
module matrix_mult_mxn
    import mat_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned M     = 4,
    parameter int unsigned K     = 4,
    parameter int unsigned N     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_en,
    matrix_mult_mxn_if.slave   bus
);
    localparam int unsigned ACCW = acc_width(WIDTH, K);
    localparam int unsigned KW   = (K > 1) ? $clog2(K) : 1;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic            trans_b_q, trans_b_d;
    logic            load;
    logic            last;
    logic [M*N-1:0]  sat_vec;

    assign last = (k_q == KW'(K - 1));

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        trans_b_d = trans_b_q;
        load      = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d   = RUN;
                    k_d       = '0;
                    trans_b_d = bus.trans_b;
                    load      = clk_en;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (last) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            trans_b_q <= 1'b0;
        end else if (clk_en) begin
            state_q   <= state_d;
            k_q       <= k_d;
            trans_b_q <= trans_b_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && load && bus.trans_b) begin
            assert (K == N) else $error("matrix_mult_mxn: trans_b requires K == N");
        end
    end

    for (genvar i = 0; i < M; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic signed [ACCW-1:0]  init_v;
            logic        [WIDTH-1:0] b_sel;
            logic signed [WIDTH-1:0] res_w;

            // acc_mode only matters at the start edge, where it selects the
            // accumulator seed; the seed itself is the latched form of the mode.
            assign init_v = bus.acc_mode ? (ACCW'(signed'(bus.C_in[i][j])) <<< FRAC) : '0;

            if (K == N) begin : g_tr
                assign b_sel = trans_b_q ? bus.B[j][k_q] : bus.B[k_q][j];
            end else begin : g_notr
                // Transpose is illegal for non-square B; it contributes zero.
                assign b_sel = trans_b_q ? '0 : bus.B[k_q][j];
            end

            mac_cell #(
                .WIDTH (WIDTH),
                .FRAC  (FRAC),
                .ACCW  (ACCW)
            ) u_cell (
                .clk    (clk),
                .rst_n  (rst_n),
                .load_i (load),
                .en_i   (clk_en && (state_q == RUN)),
                .last_i (last),
                .a_i    (bus.A[i][k_q]),
                .b_i    (b_sel),
                .init_i (init_v),
                .res_o  (res_w),
                .sat_o  (sat_vec[i*N+j])
            );

            assign bus.Res[i][j] = res_w;
        end
    end

    assign bus.sat  = |sat_vec;
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_matrix_mult_mxn.sv
// Directed bench for matrix_mult_mxn: three instances (2x2x2, 2x3x2, 1x1x1),
// hand-computed Q8.8 expectations.
module tb_matrix_mult_mxn;
    logic clk = 1'b0;
    logic rst_n;
    logic clk_en;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    matrix_mult_mxn_if #(.WIDTH(16), .M(1), .K(1), .N(1)) i1 ();
    matrix_mult_mxn_if #(.WIDTH(16), .M(2), .K(2), .N(2)) i2 ();
    matrix_mult_mxn_if #(.WIDTH(16), .M(2), .K(3), .N(2)) i3 ();

    matrix_mult_mxn #(.WIDTH(16), .FRAC(8), .M(1), .K(1), .N(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bus(i1));
    matrix_mult_mxn #(.WIDTH(16), .FRAC(8), .M(2), .K(2), .N(2)) u2 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bus(i2));
    matrix_mult_mxn #(.WIDTH(16), .FRAC(8), .M(2), .K(3), .N(2)) u3 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bus(i3));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v, input logic am, input logic tr);
        case (sel)
            1: begin i1.start = v; i1.acc_mode = am; i1.trans_b = tr; end
            2: begin i2.start = v; i2.acc_mode = am; i2.trans_b = tr; end
            default: begin i3.start = v; i3.acc_mode = am; i3.trans_b = tr; end
        endcase
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            1: return i1.done;
            2: return i2.done;
            default: return i3.done;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            1: return i1.busy;
            2: return i2.busy;
            default: return i3.busy;
        endcase
    endfunction

    function automatic logic get_sat(input int sel);
        case (sel)
            1: return i1.sat;
            2: return i2.sat;
            default: return i3.sat;
        endcase
    endfunction

    function automatic logic [15:0] get_res(input int sel, input int i, input int j);
        logic ii;
        logic jj;
        ii = i[0];
        jj = j[0];
        case (sel)
            2: return i2.Res[ii][jj];
            3: return i3.Res[ii][jj];
            default: return i1.Res[0][0];
        endcase
    endfunction

    // Start a run, wait (bounded) for done, check latency in enabled cycles,
    // then check that done drops after one cycle.
    task automatic run(input int sel, input logic am, input logic tr, input logic toggle,
                       input logic pulse, input int exp_lat, input string tag);
        int   cyc;
        int   ecyc;
        logic en_prev;
        @(negedge clk);
        set_start(sel, 1'b1, am, tr);
        @(negedge clk);
        set_start(sel, 1'b0, am, tr);
        check({tag, ".busy"}, 64'(get_busy(sel)), 64'(1));
        if (toggle) clk_en = 1'b0;
        cyc  = 0;
        ecyc = 0;
        while (!get_done(sel) && cyc < 50) begin
            en_prev = clk_en;
            @(negedge clk);
            cyc++;
            if (en_prev) ecyc++;
            if (toggle) clk_en = ~clk_en;
            if (pulse && cyc == 1) set_start(sel, 1'b1, am, tr);
            if (pulse && cyc == 2) set_start(sel, 1'b0, am, tr);
        end
        clk_en = 1'b1;
        set_start(sel, 1'b0, am, tr);
        check({tag, ".latency"}, 64'(ecyc), 64'(exp_lat));
        check({tag, ".done"}, 64'(get_done(sel)), 64'(1));
        @(negedge clk);
        check({tag, ".done_drop"}, 64'(get_done(sel)), 64'(0));
    endtask

    task automatic check_res(input int sel, input string tag,
                             input logic [15:0] e00, input logic [15:0] e01,
                             input logic [15:0] e10, input logic [15:0] e11,
                             input logic esat);
        logic [15:0] e [2][2];
        e = '{'{e00, e01}, '{e10, e11}};
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                check($sformatf("%s.res[%0d][%0d]", tag, i, j),
                      64'(get_res(sel, i, j)), 64'(e[i][j]));
            end
        end
        check({tag, ".sat"}, 64'(get_sat(sel)), 64'(esat));
    endtask

    task automatic set2(input logic [15:0] a00, input logic [15:0] a01,
                        input logic [15:0] a10, input logic [15:0] a11,
                        input logic [15:0] b00, input logic [15:0] b01,
                        input logic [15:0] b10, input logic [15:0] b11);
        i2.A[0][0] = a00; i2.A[0][1] = a01; i2.A[1][0] = a10; i2.A[1][1] = a11;
        i2.B[0][0] = b00; i2.B[0][1] = b01; i2.B[1][0] = b10; i2.B[1][1] = b11;
    endtask

    task automatic run1(input logic [15:0] a, input logic [15:0] b, input logic [15:0] er,
                        input logic es, input string tag);
        i1.A[0][0] = a;
        i1.B[0][0] = b;
        run(1, 1'b0, 1'b0, 1'b0, 1'b0, 1, tag);
        check({tag, ".res"}, 64'(i1.Res[0][0]), 64'(er));
        check({tag, ".sat"}, 64'(i1.sat), 64'(es));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n  = 1'b0;
        clk_en = 1'b1;
        i1.start = 1'b0; i1.acc_mode = 1'b0; i1.trans_b = 1'b0;
        i1.A = '0; i1.B = '0; i1.C_in = '0;
        i2.start = 1'b0; i2.acc_mode = 1'b0; i2.trans_b = 1'b0;
        i2.A = '0; i2.B = '0; i2.C_in = '0;
        i3.start = 1'b0; i3.acc_mode = 1'b0; i3.trans_b = 1'b0;
        i3.A = '0; i3.B = '0; i3.C_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_res(2, "reset2", 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        check("reset2.busy", 64'(i2.busy), 64'(0));
        check("reset2.done", 64'(i2.done), 64'(0));

        // A = I, B passes through unchanged
        set2(16'h0100, 16'h0000, 16'h0000, 16'h0100,
             16'h0200, 16'h0080, 16'hFF00, 16'h0100);
        run(2, 1'b0, 1'b0, 1'b0, 1'b0, 2, "ident");
        check_res(2, "ident", 16'h0200, 16'h0080, 16'hFF00, 16'h0100, 1'b0);

        // Accumulate form: C_in = 1.0 everywhere
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                i2.C_in[i][j] = 16'h0100;
        run(2, 1'b1, 1'b0, 1'b0, 1'b0, 2, "accum");
        check_res(2, "accum", 16'h0300, 16'h0180, 16'h0000, 16'h0200, 1'b0);

        // Transposed B, acc_mode off so C_in must be ignored
        set2(16'h0100, 16'h0000, 16'h0000, 16'h0100,
             16'h0100, 16'h0200, 16'h0300, 16'h0400);
        run(2, 1'b0, 1'b1, 1'b0, 1'b0, 2, "trans");
        check_res(2, "trans", 16'h0100, 16'h0300, 16'h0200, 16'h0400, 1'b0);

        // 1x1 saturation and floor rounding
        run1(16'h7F00, 16'h0200, 16'h7FFF, 1'b1, "satpos");
        run1(16'h7F00, 16'hFE00, 16'h8000, 1'b1, "satneg");
        run1(16'hFF80, 16'hFF80, 16'h0040, 1'b0, "halfsq");
        run1(16'h0001, 16'hFF80, 16'hFFFF, 1'b0, "floor");

        // 2x3x2 with clk_en toggling and a start pulse mid-RUN
        i3.A[0][0] = 16'h0100; i3.A[0][1] = 16'h0200; i3.A[0][2] = 16'h0300;
        i3.A[1][0] = 16'h0400; i3.A[1][1] = 16'h0500; i3.A[1][2] = 16'h0600;
        i3.B[0][0] = 16'h0380; i3.B[0][1] = 16'h0400;
        i3.B[1][0] = 16'h0480; i3.B[1][1] = 16'h0500;
        i3.B[2][0] = 16'h0580; i3.B[2][1] = 16'h0600;
        run(3, 1'b0, 1'b0, 1'b1, 1'b1, 3, "rect_en");
        check_res(3, "rect_en", 16'h1D00, 16'h2000, 16'h4580, 16'h4D00, 1'b0);

        // 2x3x2 integer case: row 1 (139, 154) exceeds Q8.8 range and clamps
        i3.B[0][0] = 16'h0700; i3.B[0][1] = 16'h0800;
        i3.B[1][0] = 16'h0900; i3.B[1][1] = 16'h0A00;
        i3.B[2][0] = 16'h0B00; i3.B[2][1] = 16'h0C00;
        run(3, 1'b0, 1'b0, 1'b0, 1'b0, 3, "rect");
        check_res(3, "rect", 16'h3A00, 16'h4000, 16'h7FFF, 16'h7FFF, 1'b1);

        // Reset mid-RUN (k = 1)
        set2(16'h0100, 16'h0000, 16'h0000, 16'h0100,
             16'h0200, 16'h0080, 16'hFF00, 16'h0100);
        @(negedge clk);
        set_start(2, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        set_start(2, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("midrst.busy_before", 64'(i2.busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check_res(2, "midrst", 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        check("midrst.busy", 64'(i2.busy), 64'(0));
        check("midrst.done", 64'(i2.done), 64'(0));
        check("midrst.sat3", 64'(i3.sat), 64'(0));
        check("midrst.res3", 64'(i3.Res[1][1]), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run(2, 1'b0, 1'b0, 1'b0, 1'b0, 2, "postrst");
        check_res(2, "postrst", 16'h0200, 16'h0080, 16'hFF00, 16'h0100, 1'b0);

        // Back-to-back: start held high through DONE
        i2.C_in = '0;
        @(negedge clk);
        set_start(2, 1'b1, 1'b0, 1'b0);
        cyc = 0;
        while (!i2.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        // count includes the start edge itself
        check("b2b.lat1", 64'(cyc), 64'(3));
        check_res(2, "b2b1", 16'h0200, 16'h0080, 16'hFF00, 16'h0100, 1'b0);
        set2(16'h0200, 16'h0000, 16'h0000, 16'h0200,
             16'h0200, 16'h0080, 16'hFF00, 16'h0100);
        @(negedge clk);
        check("b2b.busy", 64'(i2.busy), 64'(1));
        check("b2b.done", 64'(i2.done), 64'(0));
        set_start(2, 1'b0, 1'b0, 1'b0);
        cyc = 0;
        while (!i2.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b.lat2", 64'(cyc), 64'(2));
        check_res(2, "b2b2", 16'h0400, 16'h0100, 16'hFE00, 16'h0200, 1'b0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
